pred_collect: RTL and testbench
===============================

PRED_COLLECT -- requirements
Module: pred_collect

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge), rst input 1.
REQ-002 br_valid  input  1  branch fetched this cycle; addr and bank predictions are valid.
REQ-003 addr  input  3  bank select: 3'b001 selects bank A, 3'b010 selects bank B, all other values select no bank.
REQ-004 predA  input  1  prediction from bank A (1 = taken).
REQ-005 predB  input  1  prediction from bank B.
REQ-006 resolve  input  1  outcome of the pending branch is valid this cycle.
REQ-007 otcome  input  1  actual outcome (1 = taken), qualified by resolve.
REQ-008 pred  output  1  registered selected prediction.
REQ-009 pred_valid  output  1  one-cycle pulse qualifying pred.
REQ-010 busy  output  1  a branch is pending; br_valid is not accepted.
REQ-011 miss  output  1  registered mispredict flag, qualified by miss_valid.
REQ-012 miss_valid  output  1  one-cycle pulse; the update for the bank demux is valid.
REQ-013 addr_out  output  3  latched addr of the resolving branch, driven to the 1-to-2 update demux.
REQ-014 otcome_out  output  1  registered otcome, qualified by miss_valid.
REQ-015 cntA, cntB  output  8 each  per-bank mispredict counts (see Configuration).

Function
REQ-016 FSM SHALL have two states: IDLE and WAIT.
REQ-017 IDLE with br_valid=1 and addr in {001,010}: latch addr and the selected bank's prediction; next cycle pred=latched value, pred_valid=1 for exactly one cycle, busy=1, state=WAIT.
REQ-018 IDLE with br_valid=1 and any other addr: request is ignored; no pred_valid; state stays IDLE.
REQ-019 IDLE with resolve=1: resolve is ignored; no miss_valid.
REQ-020 WAIT with br_valid=1: request is dropped; busy is already 1 so the source is responsible.
REQ-021 WAIT with resolve=1: next cycle miss=(latched pred XOR otcome), otcome_out=otcome, addr_out=latched addr, miss_valid=1 for exactly one cycle, busy=0, state=IDLE.
REQ-022 Latency: br_valid to pred_valid is 1 cycle; resolve to miss_valid is 1 cycle.
REQ-023 A br_valid in the cycle miss_valid is high SHALL be accepted (back-to-back throughput of 1 branch per 2 cycles minimum).
REQ-024 A resolve arriving in the same cycle as the br_valid accepted from IDLE SHALL be ignored.
REQ-025 pred, miss, otcome_out and addr_out SHALL hold their last values when not qualified.

Reset
REQ-026 rst=1 SHALL force state=IDLE and force pred, pred_valid, busy, miss, miss_valid and otcome_out to 0, addr_out to 3'b000, and cntA and cntB to 0, on the next clk edge.
REQ-027 Reset during WAIT SHALL discard the pending branch with no miss_valid.

Configuration
REQ-028 Macro PRED_COLLECT_STATS_EN.
- Defined: on each miss_valid with miss=1, the counter for bank addr_out (A or B) increments.
- Counter saturates at 8'hFF.
- Defined: counter updates are visible the cycle after miss_valid.
- Undefined: cntA and cntB are tied to 8'h00, and no counter flops are built.

Structure
REQ-029 Shared package pred_pkg SHALL hold:
- the state enum (IDLE, WAIT);
- ADDR_A=3'b001 and ADDR_B=3'b010;
- CNT_W=8.
REQ-030 One sub-module, sat_counter (CNT_W wide, synchronous clear, saturating increment), SHALL be instantiated twice under PRED_COLLECT_STATS_EN.

Verification
REQ-031 addr=001, predA=1, predB=0, br_valid pulse; two cycles later resolve=1 with otcome=0 -> pred=1 with pred_valid; then miss=1, addr_out=001, otcome_out=0; with stats, cntA=1.
REQ-032 addr=010, predB=1, otcome=1 -> miss=0 and miss_valid; cntB unchanged.
REQ-033 addr=011 or 000 with br_valid -> no pred_valid and busy stays 0; resolve in IDLE -> no miss_valid.
REQ-034 In WAIT, a second br_valid with addr=001 -> dropped; exactly one pred_valid; a br_valid in the miss_valid cycle -> accepted, with pred_valid on the next cycle.
REQ-035 Stats: 260 consecutive bank-A mispredicts -> cntA=8'hFF; without the macro -> cntA=0.
REQ-036 rst asserted in WAIT -> next cycle busy=0 and all outputs 0; a later resolve produces no miss_valid.

Source files
------------

// File: rtl/pred_pkg.sv
// Shared types and constants for the branch prediction collector.
package pred_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CNT_W  = 8;

    localparam logic [ADDR_W-1:0] ADDR_A = 3'b001;
    localparam logic [ADDR_W-1:0] ADDR_B = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // True when the address selects one of the two prediction banks.
    function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
        return (a == ADDR_A) || (a == ADDR_B);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Clear wins; otherwise count up and stick at all-ones.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pred_collect.sv
// Collects a bank prediction for one outstanding branch and reports the
// mispredict when the branch resolves.
// Optional per-bank mispredict counters: define PRED_COLLECT_STATS_EN.
module pred_collect
    import pred_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic              predA,
    input  logic              predB,
    input  logic              resolve,
    input  logic              otcome,
    output logic              pred,
    output logic              pred_valid,
    output logic              busy,
    output logic              miss,
    output logic              miss_valid,
    output logic [ADDR_W-1:0] addr_out,
    output logic              otcome_out,
    output logic [CNT_W-1:0]  cntA,
    output logic [CNT_W-1:0]  cntB
);

    state_t            r_state, w_state_nxt;
    logic              r_pred, w_pred_nxt;
    logic              r_pred_valid, w_pred_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_miss, w_miss_nxt;
    logic              r_miss_valid, w_miss_valid_nxt;
    logic [ADDR_W-1:0] r_addr_out, w_addr_out_nxt;
    logic              r_otcome_out, w_otcome_out_nxt;
    logic [ADDR_W-1:0] r_laddr, w_laddr_nxt;

    // State and output registers; reset drops any pending branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pred       <= 1'b0;
            r_pred_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_miss       <= 1'b0;
            r_miss_valid <= 1'b0;
            r_addr_out   <= '0;
            r_otcome_out <= 1'b0;
            r_laddr      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pred       <= w_pred_nxt;
            r_pred_valid <= w_pred_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_miss       <= w_miss_nxt;
            r_miss_valid <= w_miss_valid_nxt;
            r_addr_out   <= w_addr_out_nxt;
            r_otcome_out <= w_otcome_out_nxt;
            r_laddr      <= w_laddr_nxt;
        end
    end

    // Next state and next outputs; qualified outputs hold, pulses default low.
    always_comb begin
        w_state_nxt      = r_state;
        w_pred_nxt       = r_pred;
        w_pred_valid_nxt = 1'b0;
        w_busy_nxt       = r_busy;
        w_miss_nxt       = r_miss;
        w_miss_valid_nxt = 1'b0;
        w_addr_out_nxt   = r_addr_out;
        w_otcome_out_nxt = r_otcome_out;
        w_laddr_nxt      = r_laddr;
        case (r_state)
            IDLE: begin
                if (br_valid && addr_hit(addr)) begin
                    w_state_nxt      = WAIT;
                    w_laddr_nxt      = addr;
                    w_pred_nxt       = (addr == ADDR_A) ? predA : predB;
                    w_pred_valid_nxt = 1'b1;
                    w_busy_nxt       = 1'b1;
                end
            end
            WAIT: begin
                if (resolve) begin
                    w_state_nxt      = IDLE;
                    w_miss_nxt       = r_pred ^ otcome;
                    w_otcome_out_nxt = otcome;
                    w_addr_out_nxt   = r_laddr;
                    w_miss_valid_nxt = 1'b1;
                    w_busy_nxt       = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign pred       = r_pred;
    assign pred_valid = r_pred_valid;
    assign busy       = r_busy;
    assign miss       = r_miss;
    assign miss_valid = r_miss_valid;
    assign addr_out   = r_addr_out;
    assign otcome_out = r_otcome_out;

`ifdef PRED_COLLECT_STATS_EN
    logic w_inc_a;
    logic w_inc_b;

    assign w_inc_a = r_miss_valid && r_miss && (r_addr_out == ADDR_A);
    assign w_inc_b = r_miss_valid && r_miss && (r_addr_out == ADDR_B);

    sat_counter #(.W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_inc_a),
        .o_cnt (cntA)
    );

    sat_counter #(.W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_inc_b),
        .o_cnt (cntB)
    );
`else
    assign cntA = '0;
    assign cntB = '0;
`endif

endmodule

// File: tb/tb_pred_collect.sv
// Bench for pred_collect: directed scenarios plus random traffic against a
// transaction-level reference model.
module tb_pred_collect;
    import pred_pkg::*;

    logic       clk = 1'b0;
    logic       rst, br_valid, predA, predB, resolve, otcome;
    logic [2:0] addr;
    logic       pred, pred_valid, busy, miss, miss_valid, otcome_out;
    logic [2:0] addr_out;
    logic [7:0] cntA, cntB;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one pending branch slot plus the last reported values.
    bit       m_pending;
    bit       m_lpred;
    bit [2:0] m_laddr;
    bit       m_pred, m_pv, m_busy, m_miss, m_mv, m_oout;
    bit [2:0] m_aout;
    int       m_cnt_a, m_cnt_b;
    int       pv_seen;

    pred_collect dut (
        .clk        (clk),
        .rst        (rst),
        .br_valid   (br_valid),
        .addr       (addr),
        .predA      (predA),
        .predB      (predB),
        .resolve    (resolve),
        .otcome     (otcome),
        .pred       (pred),
        .pred_valid (pred_valid),
        .busy       (busy),
        .miss       (miss),
        .miss_valid (miss_valid),
        .addr_out   (addr_out),
        .otcome_out (otcome_out),
        .cntA       (cntA),
        .cntB       (cntB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_step(input bit r, input bit bv, input bit [2:0] a, input bit pa,
                              input bit pb, input bit res, input bit oc);
        if (r) begin
            m_pending = 0; m_lpred = 0; m_laddr = 0;
            m_pred = 0; m_pv = 0; m_busy = 0; m_miss = 0; m_mv = 0; m_oout = 0; m_aout = 0;
            m_cnt_a = 0; m_cnt_b = 0;
        end else begin
`ifdef PRED_COLLECT_STATS_EN
            if (m_mv && m_miss && m_aout == 3'b001 && m_cnt_a < 255) m_cnt_a++;
            if (m_mv && m_miss && m_aout == 3'b010 && m_cnt_b < 255) m_cnt_b++;
`endif
            m_pv = 0;
            m_mv = 0;
            if (!m_pending) begin
                if (bv && (a == 3'b001 || a == 3'b010)) begin
                    m_pending = 1;
                    m_laddr   = a;
                    m_lpred   = (a == 3'b001) ? pa : pb;
                    m_pred    = m_lpred;
                    m_pv      = 1;
                end
            end else if (res) begin
                m_pending = 0;
                m_mv      = 1;
                m_miss    = m_lpred ^ oc;
                m_oout    = oc;
                m_aout    = m_laddr;
            end
            m_busy = m_pending;
        end
    endtask

    // Drive one cycle, advance the model, and compare every output.
    task automatic step(input bit r, input bit bv, input bit [2:0] a, input bit pa,
                        input bit pb, input bit res, input bit oc);
        rst = r; br_valid = bv; addr = a; predA = pa; predB = pb; resolve = res; otcome = oc;
        @(posedge clk);
        #1;
        model_step(r, bv, a, pa, pb, res, oc);
        if (pred_valid) pv_seen++;
        chk("pred_valid", 32'(pred_valid), 32'(m_pv));
        chk("miss_valid", 32'(miss_valid), 32'(m_mv));
        chk("busy",       32'(busy),       32'(m_busy));
        chk("pred",       32'(pred),       32'(m_pred));
        chk("miss",       32'(miss),       32'(m_miss));
        chk("addr_out",   32'(addr_out),   32'(m_aout));
        chk("otcome_out", 32'(otcome_out), 32'(m_oout));
        chk("cntA",       32'(cntA),       32'(m_cnt_a));
        chk("cntB",       32'(cntB),       32'(m_cnt_b));
    endtask

    task automatic idle_cycle();
        step(0, 0, 3'b000, 0, 0, 0, 0);
    endtask

    initial begin
        bit [2:0] ra;
        pv_seen = 0;

        // Reset state.
        step(1, 0, 3'b000, 0, 0, 0, 0);
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_addr_out",   32'(addr_out),   32'd0);
        chk("rst_cntA",       32'(cntA),       32'd0);

        // Bank A mispredict.
        step(0, 1, 3'b001, 1, 0, 0, 0);
        chk("a_pred", 32'(pred), 32'd1);
        chk("a_pv",   32'(pred_valid), 32'd1);
        idle_cycle();
        step(0, 0, 3'b000, 0, 0, 1, 0);
        chk("a_miss", 32'(miss), 32'd1);
        chk("a_mv",   32'(miss_valid), 32'd1);
        chk("a_aout", 32'(addr_out), 32'd1);
        idle_cycle();
`ifdef PRED_COLLECT_STATS_EN
        chk("a_cntA", 32'(cntA), 32'd1);
`else
        chk("a_cntA", 32'(cntA), 32'd0);
`endif

        // Bank B correct prediction.
        step(0, 1, 3'b010, 0, 1, 0, 0);
        step(0, 0, 3'b000, 0, 0, 1, 1);
        chk("b_miss", 32'(miss), 32'd0);
        chk("b_mv",   32'(miss_valid), 32'd1);
        idle_cycle();
        chk("b_cntB", 32'(cntB), 32'd0);

        // Unselected addresses and resolve in IDLE are ignored.
        step(0, 1, 3'b011, 1, 1, 0, 0);
        chk("bad3_busy", 32'(busy), 32'd0);
        step(0, 1, 3'b000, 1, 1, 1, 0);
        chk("bad0_pv", 32'(pred_valid), 32'd0);
        chk("idle_res_mv", 32'(miss_valid), 32'd0);

        // Second request while pending is dropped; request in miss_valid cycle accepted.
        pv_seen = 0;
        step(0, 1, 3'b001, 0, 1, 0, 0);
        step(0, 1, 3'b001, 1, 1, 0, 0);
        step(0, 1, 3'b010, 1, 1, 0, 0);
        chk("drop_count", 32'(pv_seen), 32'd1);
        step(0, 0, 3'b000, 0, 0, 1, 1);
        step(0, 1, 3'b010, 0, 1, 0, 0);
        chk("b2b_pv",   32'(pred_valid), 32'd1);
        chk("b2b_pred", 32'(pred), 32'd1);

        // Reset in WAIT discards the pending branch.
        step(1, 0, 3'b000, 0, 0, 0, 0);
        chk("rstw_busy", 32'(busy), 32'd0);
        step(0, 0, 3'b000, 0, 0, 1, 1);
        chk("rstw_mv", 32'(miss_valid), 32'd0);

        // Counter saturation: 260 bank-A mispredicts, back to back.
        for (int i = 0; i < 260; i++) begin
            step(0, 1, 3'b001, 1, 0, 0, 0);
            step(0, 0, 3'b000, 0, 0, 1, 0);
        end
        idle_cycle();
`ifdef PRED_COLLECT_STATS_EN
        chk("sat_cntA", 32'(cntA), 32'hFF);
`else
        chk("sat_cntA", 32'(cntA), 32'h00);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            ra = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ra = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), ra,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
